// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage: ID/EX pipeline register with ALU-control decode and operand forwarding.
// Define ALU_FORWARD_EN to forward EX/MEM and MEM/WB results onto the operands.
module id_ex_alu_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [5:0]          id_opcode,
  input  logic [5:0]          id_funct,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic [WIDTH-1:0]    id_rs_data,
  input  logic [WIDTH-1:0]    id_rt_data,
  input  logic [15:0]         id_imm,
  input  logic                exmem_regwrite,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]    exmem_result,
  input  logic                memwb_regwrite,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]    memwb_result,
  output logic                ex_valid,
  output logic [3:0]          ex_alu_op,
  output logic                ex_sub,
  output logic                ex_cin,
  output logic [WIDTH-1:0]    ex_a,
  output logic [WIDTH-1:0]    ex_b,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic [REG_BITS-1:0] ex_dest,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_branch,
  output logic                ex_illegal
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;
  logic                w_ok, w_rtype, w_use_imm, w_sext, w_wr, w_mr, w_mw, w_br;
  logic [3:0]          w_op;
  logic [REG_BITS-1:0] w_dest;
  logic [WIDTH-1:0]    w_imm, w_rs_fwd, w_rt_fwd;
  logic                r_valid, r_sub, r_regwrite, r_memread, r_memwrite, r_branch;
  logic                r_illegal, r_use_imm;
  logic [3:0]          r_alu_op;
  logic [REG_BITS-1:0] r_dest, r_rs, r_rt;
  logic [WIDTH-1:0]    r_rs_data, r_rt_data, r_imm;
  always_comb begin
    w_ok      = 1'b1;
    w_op      = OP_AND;
    w_rtype   = 1'b0;
    w_use_imm = 1'b0;
    w_sext    = 1'b1;
    w_wr      = 1'b0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_br      = 1'b0;
    case (id_opcode)
      6'h00: begin
        w_rtype = 1'b1;
        w_wr    = 1'b1;
        case (id_funct)
          6'h20, 6'h21: w_op = OP_ADD;
          6'h22, 6'h23: w_op = OP_SUB;
          6'h24:        w_op = OP_AND;
          6'h25:        w_op = OP_OR;
          6'h27:        w_op = OP_NOR;
          6'h2A:        w_op = OP_SLT;
          default:      w_ok = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin w_op = OP_ADD; w_use_imm = 1'b1; w_wr = 1'b1; end
      6'h0A:        begin w_op = OP_SLT; w_use_imm = 1'b1; w_wr = 1'b1; end
      6'h0C:        begin w_op = OP_AND; w_use_imm = 1'b1; w_wr = 1'b1; w_sext = 1'b0; end
      6'h0D:        begin w_op = OP_OR;  w_use_imm = 1'b1; w_wr = 1'b1; w_sext = 1'b0; end
      6'h23:        begin w_op = OP_ADD; w_use_imm = 1'b1; w_wr = 1'b1; w_mr = 1'b1; end
      6'h2B:        begin w_op = OP_ADD; w_use_imm = 1'b1; w_mw = 1'b1; end
      6'h04, 6'h05: begin w_op = OP_SUB; w_br = 1'b1; end
      default:      w_ok = 1'b0;
    endcase
  end
  assign w_dest = w_rtype ? id_rd : id_rt;
  assign w_imm  = w_sext ? {{(WIDTH-16){id_imm[15]}}, id_imm} : {{(WIDTH-16){1'b0}}, id_imm};
  // Bubbles clear every field, so a dead slot never forwards or writes back.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !(id_valid && w_ok))) begin
      r_valid    <= 1'b0;
      r_alu_op   <= OP_AND;
      r_sub      <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_illegal  <= !rst && !flush && id_valid && !w_ok;
      r_use_imm  <= 1'b0;
      r_dest     <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
    end else if (!stall) begin
      r_valid    <= 1'b1;
      r_alu_op   <= w_op;
      r_sub      <= (w_op == OP_SUB) || (w_op == OP_SLT);
      r_regwrite <= w_wr && (w_dest != '0);
      r_memread  <= w_mr;
      r_memwrite <= w_mw;
      r_branch   <= w_br;
      r_illegal  <= 1'b0;
      r_use_imm  <= w_use_imm;
      r_dest     <= w_dest;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= w_imm;
    end
  end
`ifdef ALU_FORWARD_EN
  logic w_rs_ex, w_rs_wb, w_rt_ex, w_rt_wb;
  assign w_rs_ex  = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs);
  assign w_rs_wb  = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs);
  assign w_rt_ex  = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt);
  assign w_rt_wb  = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt);
  assign w_rs_fwd = w_rs_ex ? exmem_result : w_rs_wb ? memwb_result : r_rs_data;
  assign w_rt_fwd = w_rt_ex ? exmem_result : w_rt_wb ? memwb_result : r_rt_data;
`else
  logic w_unused;
  assign w_unused = ^{exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd,
                      memwb_result, r_rs, r_rt};
  assign w_rs_fwd = r_rs_data;
  assign w_rt_fwd = r_rt_data;
`endif
  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_alu_op;
  assign ex_sub        = r_sub;
  assign ex_cin        = r_sub;
  assign ex_a          = w_rs_fwd;
  assign ex_b          = r_use_imm ? r_imm : w_rt_fwd;
  assign ex_store_data = w_rt_fwd;
  assign ex_dest       = r_dest;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;
  assign ex_branch     = r_branch;
  assign ex_illegal    = r_illegal;
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// tb_id_ex_alu_stage: directed self-checking bench for id_ex_alu_stage.
module tb_id_ex_alu_stage;
  logic        clk = 1'b0, rst, stall, flush, id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd, ex_dest;
  logic [31:0] id_rs_data, id_rt_data, exmem_result, memwb_result;
  logic [15:0] id_imm;
  logic        exmem_regwrite, memwb_regwrite;
  logic        ex_valid, ex_sub, ex_cin, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_store_data;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  id_ex_alu_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_sub(ex_sub), .ex_cin(ex_cin),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ctrl(input string tag, input logic v, input logic [3:0] op, input logic rw,
                      input logic mr, input logic mw, input logic br, input logic ill);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(v));
    chk({tag, ".op"}, 32'(ex_alu_op), 32'(op));
    chk({tag, ".regwrite"}, 32'(ex_regwrite), 32'(rw));
    chk({tag, ".memread"}, 32'(ex_memread), 32'(mr));
    chk({tag, ".memwrite"}, 32'(ex_memwrite), 32'(mw));
    chk({tag, ".branch"}, 32'(ex_branch), 32'(br));
    chk({tag, ".illegal"}, 32'(ex_illegal), 32'(ill));
    chk({tag, ".sub"}, 32'(ex_sub), 32'(op == 4'b0110 || op == 4'b0111));
    chk({tag, ".cin"}, 32'(ex_cin), 32'(op == 4'b0110 || op == 4'b0111));
  endtask
  initial begin
    rst = 1; stall = 0; flush = 0; id_valid = 1;
    id_opcode = 6'h00; id_funct = 6'h22; id_rs = 1; id_rt = 2; id_rd = 5;
    id_rs_data = 32'd7; id_rt_data = 32'd3; id_imm = 16'h1234;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    step(); step();
    ctrl("reset", 0, 4'b0000, 0, 0, 0, 0, 0);
    chk("reset.a", ex_a, 32'h0);
    chk("reset.b", ex_b, 32'h0);
    chk("reset.dest", 32'(ex_dest), 32'h0);
    rst = 0;
    step();
    ctrl("sub", 1, 4'b0110, 1, 0, 0, 0, 0);
    chk("sub.a", ex_a, 32'd7);
    chk("sub.b", ex_b, 32'd3);
    chk("sub.dest", 32'(ex_dest), 32'd5);
    chk("sub.store", ex_store_data, 32'd3);
    id_opcode = 6'h08; id_rt = 6; id_imm = 16'hFFFF;
    step();
    ctrl("addi", 1, 4'b0010, 1, 0, 0, 0, 0);
    chk("addi.b", ex_b, 32'hFFFF_FFFF);
    chk("addi.dest", 32'(ex_dest), 32'd6);
    id_opcode = 6'h0C;
    step();
    ctrl("andi", 1, 4'b0000, 1, 0, 0, 0, 0);
    chk("andi.b", ex_b, 32'h0000_FFFF);
    id_opcode = 6'h23; id_imm = 16'h0010;
    step();
    ctrl("lw", 1, 4'b0010, 1, 1, 0, 0, 0);
    chk("lw.b", ex_b, 32'h10);
    id_opcode = 6'h2B; id_rt_data = 32'hCAFE;
    step();
    ctrl("sw", 1, 4'b0010, 0, 0, 1, 0, 0);
    chk("sw.store", ex_store_data, 32'hCAFE);
    chk("sw.b", ex_b, 32'h10);
    id_opcode = 6'h04;
    step();
    ctrl("beq", 1, 4'b0110, 0, 0, 0, 1, 0);
    chk("beq.b", ex_b, 32'hCAFE);
    id_opcode = 6'h0A; id_rt = 0; id_imm = 16'h8000;
    step();
    ctrl("slti_r0", 1, 4'b0111, 0, 0, 0, 0, 0);
    chk("slti.b", ex_b, 32'hFFFF_8000);
    id_opcode = 6'h00; id_funct = 6'h27; id_rd = 3; id_rt = 2;
    step();
    ctrl("nor", 1, 4'b1100, 1, 0, 0, 0, 0);
    chk("nor.dest", 32'(ex_dest), 32'd3);
    id_funct = 6'h20; id_rs = 4; id_rs_data = 32'h99;
    step();
    ctrl("add", 1, 4'b0010, 1, 0, 0, 0, 0);
    stall = 1;
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 4; memwb_result = 32'h22;
    #1;
`ifdef ALU_FORWARD_EN
    chk("fwd.exmem", ex_a, 32'h11);
    exmem_regwrite = 0; #1;
    chk("fwd.memwb", ex_a, 32'h22);
`else
    chk("nofwd.a", ex_a, 32'h99);
    exmem_regwrite = 0; #1;
    chk("nofwd.a2", ex_a, 32'h99);
`endif
    stall = 0; id_rs = 0; id_rs_data = 32'h55;
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
    step();
    chk("fwd.r0", ex_a, 32'h55);
    exmem_regwrite = 0; memwb_regwrite = 0;
    id_funct = 6'h25; id_rd = 7; id_rs_data = 32'hA; id_rt_data = 32'hB;
    step();
    id_opcode = 6'h08; id_rs_data = 32'h77; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      ctrl("stall", 1, 4'b0001, 1, 0, 0, 0, 0);
      chk("stall.a", ex_a, 32'hA);
      chk("stall.b", ex_b, 32'hB);
      chk("stall.dest", 32'(ex_dest), 32'd7);
    end
    flush = 1;
    step();
    ctrl("flush", 0, 4'b0000, 0, 0, 0, 0, 0);
    stall = 0; flush = 0; id_opcode = 6'h3F;
    step();
    ctrl("illegal", 0, 4'b0000, 0, 0, 0, 0, 1);
    stall = 1;
    step();
    chk("illegal.held", 32'(ex_illegal), 32'd1);
    stall = 0; id_opcode = 6'h00; id_funct = 6'h20;
    step();
    ctrl("after_illegal", 1, 4'b0010, 1, 0, 0, 0, 0);
    id_funct = 6'h00;
    step();
    ctrl("bad_funct", 0, 4'b0000, 0, 0, 0, 0, 1);
    id_valid = 0;
    step();
    ctrl("invalid", 0, 4'b0000, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
